mem_arbiter: RTL and testbench

//  Owns the single byte-wide RAM port and shares it between instruction fetch (IF) and the
//  MEM stage fed by the EX/MEM pipeline register. Serialises 1/2/4-byte little-endian

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state, owner and length encodings for the byte-wide RAM arbiter.
package mem_arbiter_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_e;
    typedef enum logic {OWN_IF, OWN_MEM} owner_e;
    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_WORD = 2'd2;
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam logic STOP    = 1'b1;
    localparam logic NOSTOP  = 1'b0;
    // Reserved length code 3 falls through to a full word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        return len == LEN_BYTE ? 3'd1 : len == LEN_HALF ? 3'd2 : 3'd4;
    endfunction
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between IF fetches and MEM loads/stores,
// serialising little-endian 1/2/4-byte accesses with MEM taking priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic [DW-1:0] if_data,
    output logic          if_done,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [1:0]    mem_len,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_rdata,
    output logic          mem_done,
    output logic          stall_req_if,
    output logic          stall_req_mem,
    output logic [AW-1:0] ram_addr,
    output logic          ram_wr,
    output logic [7:0]    ram_dout,
    input  logic [7:0]    ram_din
);
    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic [2:0]    cnt_q, cnt_d, n_q, n_d, cnt_nx;
    logic [AW-1:0] base_q, base_d, ram_addr_q, ram_addr_d;
    logic [DW-1:0] wbuf_q, wbuf_d, asm_q, asm_d, if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;
    logic [DW-1:0] rd_word;
    logic [7:0]    ram_dout_q, ram_dout_d;
    logic          ram_wr_q, ram_wr_d, if_done_q, if_done_d, mem_done_q, mem_done_d;

    assign cnt_nx = cnt_q + 3'd1;
    // In READ cycle cnt (>=1) ram_din carries the byte addressed in cycle cnt-1.
    assign rd_word = asm_q | (DW'(ram_din) << {cnt_q - 3'd1, 3'b000});

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        base_d      = base_q;
        wbuf_d      = wbuf_q;
        asm_d       = asm_q;
        ram_addr_d  = ram_addr_q;
        ram_dout_d  = ram_dout_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        ram_wr_d    = DISABLE;
        if_done_d   = DISABLE;
        mem_done_d  = DISABLE;
        unique case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    owner_d    = OWN_MEM;
                    n_d        = len_bytes(mem_len);
                    base_d     = mem_addr;
                    ram_addr_d = mem_addr;
                    cnt_d      = 3'd0;
                    asm_d      = '0;
                    wbuf_d     = mem_wdata >> 8;
                    ram_dout_d = mem_wdata[7:0];
                    ram_wr_d   = mem_we;
                    state_d    = mem_we ? ST_WRITE : ST_READ;
                end else if (if_req && !if_flush) begin
                    owner_d    = OWN_IF;
                    n_d        = 3'd4;
                    base_d     = if_addr;
                    ram_addr_d = if_addr;
                    cnt_d      = 3'd0;
                    asm_d      = '0;
                    state_d    = ST_READ;
                end
            end
            ST_READ: begin
                if (owner_q == OWN_IF && if_flush) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d      = cnt_nx;
                    asm_d      = cnt_q != 3'd0 ? rd_word : asm_q;
                    ram_addr_d = cnt_nx < n_q ? base_q + AW'(cnt_nx) : ram_addr_q;
                    if (cnt_q == n_q) begin
                        state_d     = ST_DONE;
                        if_data_d   = owner_q == OWN_IF ? rd_word : if_data_q;
                        mem_rdata_d = owner_q == OWN_MEM ? rd_word : mem_rdata_q;
                        if_done_d   = owner_q == OWN_IF ? ENABLE : DISABLE;
                        mem_done_d  = owner_q == OWN_MEM ? ENABLE : DISABLE;
                    end
                end
            end
            ST_WRITE: begin
                if (cnt_nx == n_q) begin
                    state_d    = ST_DONE;
                    mem_done_d = ENABLE;
                end else begin
                    cnt_d      = cnt_nx;
                    ram_wr_d   = ENABLE;
                    ram_addr_d = base_q + AW'(cnt_nx);
                    ram_dout_d = wbuf_q[7:0];
                    wbuf_d     = wbuf_q >> 8;
                end
            end
            ST_DONE: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            cnt_q       <= '0;
            n_q         <= '0;
            base_q      <= '0;
            wbuf_q      <= '0;
            asm_q       <= '0;
            ram_addr_q  <= '0;
            ram_dout_q  <= '0;
            ram_wr_q    <= DISABLE;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= DISABLE;
            mem_done_q  <= DISABLE;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            base_q      <= base_d;
            wbuf_q      <= wbuf_d;
            asm_q       <= asm_d;
            ram_addr_q  <= ram_addr_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end
    end

    assign ram_addr      = ram_addr_q;
    assign ram_wr        = ram_wr_q;
    assign ram_dout      = ram_dout_q;
    assign if_data       = if_data_q;
    assign mem_rdata     = mem_rdata_q;
    assign if_done       = if_done_q;
    assign mem_done      = mem_done_q;
    assign stall_req_if  = if_req && !if_done_q ? STOP : NOSTOP;
    assign stall_req_mem = mem_req && !mem_done_q ? STOP : NOSTOP;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized transactions against a cycle-schedule model of the arbiter
// plus a byte-addressed RAM responder; literal checks pin the model on known cases.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, if_flush = 1'b0;
    logic [31:0] if_addr = '0;
    logic        mem_req = 1'b0, mem_we = 1'b0;
    logic [1:0]  mem_len = '0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic [7:0]  ram_din = '0;
    logic [31:0] if_data, mem_rdata, ram_addr;
    logic        if_done, mem_done, stall_req_if, stall_req_mem, ram_wr;
    logic [7:0]  ram_dout;

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_data(if_data), .if_done(if_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .stall_req_if(stall_req_if), .stall_req_mem(stall_req_mem),
        .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;
    bit chk_en = 1'b0;
    logic [31:0] got_if = '0, got_mem = '0;

    logic [7:0]  ram [bit [31:0]];
    logic [7:0]  mdl [bit [31:0]];
    bit          e_wr   [int];
    logic [31:0] e_addr [int];
    logic [7:0]  e_dout [int];
    logic [31:0] e_if   [int];
    bit          e_memd [int];
    logic [31:0] e_mrd  [int];
    bit          e_rst  [int];

    function automatic logic [7:0] dflt(input bit [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction
    function automatic logic [7:0] rd_ram(input bit [31:0] a);
        return ram.exists(a) ? ram[a] : dflt(a);
    endfunction
    function automatic logic [7:0] rd_mdl(input bit [31:0] a);
        return mdl.exists(a) ? mdl[a] : dflt(a);
    endfunction

    // RAM responder: one-cycle read latency, write on ram_wr.
    always @(posedge clk) begin
        if (!$isunknown(ram_addr)) begin
            if (ram_wr === 1'b1) ram[ram_addr] = ram_dout;
            ram_din <= rd_ram(ram_addr);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ram_wr", 32'(ram_wr), 32'(e_wr.exists(cyc)));
            if (e_addr.exists(cyc)) chk("ram_addr", ram_addr, e_addr[cyc]);
            if (e_dout.exists(cyc)) chk("ram_dout", 32'(ram_dout), 32'(e_dout[cyc]));
            chk("if_done", 32'(if_done), 32'(e_if.exists(cyc)));
            chk("mem_done", 32'(mem_done), 32'(e_memd.exists(cyc)));
            if (e_if.exists(cyc)) begin
                chk("if_data", if_data, e_if[cyc]);
                got_if = if_data;
            end
            if (e_mrd.exists(cyc)) begin
                chk("mem_rdata", mem_rdata, e_mrd[cyc]);
                got_mem = mem_rdata;
            end
            chk("stall_if", 32'(stall_req_if), 32'(if_req && !e_if.exists(cyc)));
            chk("stall_mem", 32'(stall_req_mem), 32'(mem_req && !e_memd.exists(cyc)));
            if (e_rst.exists(cyc)) begin
                chk("rst_addr", ram_addr, 32'h0);
                chk("rst_dout", 32'(ram_dout), 32'h0);
                chk("rst_if_data", if_data, 32'h0);
                chk("rst_mem_rdata", mem_rdata, 32'h0);
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) next();
    endtask

    // Request seen in cycle c is granted at the edge ending c; byte k occupies cycle c+1+k.
    task automatic sched_mem(input int c, input bit we, input logic [1:0] len,
                             input logic [31:0] a, input logic [31:0] wd, output int d);
        int n;
        logic [31:0] v;
        bit [31:0] ak;
        n = len == 2'd0 ? 1 : len == 2'd1 ? 2 : 4;
        v = '0;
        for (int k = 0; k < n; k++) begin
            ak = a + 32'(k);
            e_addr[c + 1 + k] = ak;
            if (we) begin
                e_wr[c + 1 + k] = 1'b1;
                e_dout[c + 1 + k] = wd[8*k +: 8];
                mdl[ak] = wd[8*k +: 8];
            end else begin
                v = v | (32'(rd_mdl(ak)) << (8 * k));
            end
        end
        d = we ? c + n + 1 : c + n + 2;
        e_memd[d] = 1'b1;
        if (!we) e_mrd[d] = v;
    endtask

    task automatic sched_if(input int c, input logic [31:0] a, input int fj, output int d);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            if (fj < 0 || k <= fj) e_addr[c + 1 + k] = a + 32'(k);
            v = v | (32'(rd_mdl(a + 32'(k))) << (8 * k));
        end
        if (fj < 0) begin
            d = c + 6;
            e_if[d] = v;
        end else begin
            d = c + 1 + fj;
        end
    endtask

    task automatic mem_op(input bit we, input logic [1:0] len, input logic [31:0] a,
                          input logic [31:0] wd);
        int d;
        mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = a; mem_wdata = wd;
        sched_mem(cyc, we, len, a, wd, d);
        wait_until(d);
        next();
        mem_req = 1'b0;
    endtask

    task automatic if_op(input logic [31:0] a, input int fj, input bit pre);
        int d;
        if_addr = a;
        if_req = 1'b1;
        if (pre) begin
            if_flush = 1'b1;
            next();
            if_flush = 1'b0;
        end
        sched_if(cyc, a, fj, d);
        wait_until(d);
        if (fj >= 0) if_flush = 1'b1;
        next();
        if_flush = 1'b0;
        if_req = 1'b0;
    endtask

    task automatic pair_op(input bit we, input logic [1:0] len, input logic [31:0] am,
                           input logic [31:0] wd, input logic [31:0] ai);
        int dm, di;
        mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = am; mem_wdata = wd;
        if_req = 1'b1; if_addr = ai;
        sched_mem(cyc, we, len, am, wd, dm);
        sched_if(dm + 1, ai, -1, di);
        wait_until(dm);
        next();
        mem_req = 1'b0;
        wait_until(di);
        next();
        if_req = 1'b0;
    endtask

    task automatic rst_store(input logic [31:0] a, input logic [31:0] wd);
        int c;
        c = cyc;
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2; mem_addr = a; mem_wdata = wd;
        for (int k = 0; k < 3; k++) begin
            e_wr[c + 1 + k] = 1'b1;
            e_addr[c + 1 + k] = a + 32'(k);
            e_dout[c + 1 + k] = wd[8*k +: 8];
            mdl[a + 32'(k)] = wd[8*k +: 8];
        end
        e_rst[c + 4] = 1'b1;
        wait_until(c + 3);
        rst = 1'b1;
        mem_req = 1'b0;
        next();
        rst = 1'b0;
        next();
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            ram[a + 32'(k)] = w[8*k +: 8];
            mdl[a + 32'(k)] = w[8*k +: 8];
        end
    endtask

    initial begin
        logic [31:0] a, wd;
        int kind;
        next();
        next();
        e_rst[cyc] = 1'b1;
        e_rst[cyc + 1] = 1'b1;
        chk_en = 1'b1;
        next();
        rst = 1'b0;
        next();

        preload(32'h1000, 32'h00000513);
        if_op(32'h1000, -1, 1'b0);
        chk("lit_if_fetch", got_if, 32'h00000513);

        mem_op(1'b1, 2'd2, 32'h20, 32'hDEADBEEF);
        chk("lit_sw_ram", {rd_ram(32'h23), rd_ram(32'h22), rd_ram(32'h21), rd_ram(32'h20)},
            32'hDEADBEEF);

        ram[32'h7] = 8'h9C;
        mdl[32'h7] = 8'h9C;
        pair_op(1'b0, 2'd0, 32'h7, 32'h0, 32'h1000);
        chk("lit_pair_lb", got_mem, 32'h0000009C);
        chk("lit_pair_if", got_if, 32'h00000513);

        if_op(32'h2000, 2, 1'b0);
        preload(32'h3000, 32'h44332211);
        if_op(32'h3000, -1, 1'b1);
        chk("lit_refetch", got_if, 32'h44332211);

        mem_op(1'b1, 2'd1, 32'hFFFFFFFF, 32'h0000ABCD);
        chk("lit_sh_wrap_lo", 32'(rd_ram(32'hFFFFFFFF)), 32'hCD);
        chk("lit_sh_wrap_hi", 32'(rd_ram(32'h0)), 32'hAB);

        rst_store(32'h40, 32'h01020304);
        chk("lit_rst_partial", 32'(rd_ram(32'h42)), 32'h02);

        mem_op(1'b0, 2'd1, 32'h1000, 32'h0);
        chk("lit_lh", got_mem, 32'h00000513);

        for (int i = 0; i < 80; i++) begin
            a = $urandom_range(0, 3) == 0 ? 32'hFFFFFFFF - 32'($urandom_range(0, 3)) : $urandom;
            wd = $urandom;
            kind = $urandom_range(0, 4);
            case (kind)
                0: if_op(a, $urandom_range(0, 2) == 0 ? int'($urandom_range(0, 4)) : -1,
                         1'($urandom_range(0, 1)));
                1: mem_op(1'b0, 2'($urandom_range(0, 3)), a, wd);
                2: mem_op(1'b1, 2'($urandom_range(0, 3)), a, wd);
                3: pair_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, wd,
                           $urandom_range(0, 1) == 0 ? a : $urandom);
                default: rst_store(a, wd);
            endcase
            repeat ($urandom_range(0, 2)) next();
        end
        next();
        next();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
